// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard sequencer: state encodings and
// the per-stage control bundles driven in each hazard situation.
package pipe_hazard_ctrl_pkg;

    localparam int LEN_INST_REG = 5;

    typedef enum logic [1:0] {
        HZ_RUN      = 2'd0,
        HZ_MEM_WAIT = 2'd1,
        HZ_ERR      = 2'd2
    } hz_state_e;

    typedef struct packed {
        logic pc_en;
        logic if_id_en;
        logic if_id_flush;
        logic id_ex_en;
        logic id_ex_flush;
        logic ex_mem_en;
        logic mem_wb_flush;
    } hz_ctrl_t;

    // Field order: pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_en, mem_wb_flush
    localparam hz_ctrl_t CTRL_NORMAL    = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    localparam hz_ctrl_t CTRL_MEM_STALL = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    localparam hz_ctrl_t CTRL_REDIRECT  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    localparam hz_ctrl_t CTRL_LOAD_USE  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    localparam hz_ctrl_t CTRL_HALT      = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

endpackage

// File: rtl/pipe_hazard_ctrl_sat_counter.sv
// Saturating up-counter used for the hazard performance counters.
module pipe_hazard_ctrl_sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (inc && (count_q != {CNT_W{1'b1}})) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline registers: load-use stalls,
// redirect squashes, memory-wait freezes with timeout, and perf counters.
module pipe_hazard_ctrl
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int REG_W       = LEN_INST_REG,
    parameter int CNT_W       = 16,
    parameter int MEM_TIMEOUT = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_uses_rt,
    input  logic             ex_MemRead,
    input  logic [REG_W-1:0] ex_reg,
    input  logic             ex_redirect,
    input  logic             mem_MemRead,
    input  logic             mem_MemWrite,
    input  logic             mem_ready,
    output logic             pc_en,
    output logic             if_id_en,
    output logic             if_id_flush,
    output logic             id_ex_en,
    output logic             id_ex_flush,
    output logic             ex_mem_en,
    output logic             mem_wb_flush,
    output logic             mem_err,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam int WAIT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

    hz_state_e         state_q, state_d;
    logic [WAIT_W-1:0] wait_q, wait_d;

    logic     mem_busy;
    logic     load_use;
    logic     redirect_act;
    hz_ctrl_t ctrl;

    assign mem_busy = (mem_MemRead | mem_MemWrite) & ~mem_ready;

    // $0 is hardwired to zero, so a load targeting it never creates a dependency.
    assign load_use = ex_MemRead && (ex_reg != '0) &&
                      ((ex_reg == id_rs) || (id_uses_rt && (ex_reg == id_rt)));

    always_comb begin
        ctrl         = CTRL_NORMAL;
        redirect_act = 1'b0;
        if (!rst) begin
            if (state_q == HZ_ERR) begin
                ctrl = CTRL_HALT;
            end else if (mem_busy) begin
                ctrl = CTRL_MEM_STALL;
            end else if (ex_redirect) begin
                ctrl         = CTRL_REDIRECT;
                redirect_act = 1'b1;
            end else if (load_use) begin
                ctrl = CTRL_LOAD_USE;
            end
        end
    end

    assign pc_en        = ctrl.pc_en;
    assign if_id_en     = ctrl.if_id_en;
    assign if_id_flush  = ctrl.if_id_flush;
    assign id_ex_en     = ctrl.id_ex_en;
    assign id_ex_flush  = ctrl.id_ex_flush;
    assign ex_mem_en    = ctrl.ex_mem_en;
    assign mem_wb_flush = ctrl.mem_wb_flush;
    assign mem_err      = !rst && (state_q == HZ_ERR);

    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        case (state_q)
            HZ_RUN: begin
                wait_d = '0;
                if (mem_busy) begin
                    state_d = HZ_MEM_WAIT;
                end
            end
            HZ_MEM_WAIT: begin
                if (!mem_busy) begin
                    state_d = HZ_RUN;
                    wait_d  = '0;
                end else if (wait_q == WAIT_LAST) begin
                    state_d = HZ_ERR;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            HZ_ERR: begin
                state_d = HZ_ERR;
            end
            default: begin
                state_d = HZ_RUN;
                wait_d  = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= HZ_RUN;
            wait_q  <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
        end
    end

    // Counter 0 tracks frozen-PC cycles, counter 1 tracks acted-on redirects.
    logic [1:0]       cnt_inc;
    logic [CNT_W-1:0] cnt_val [2];

    assign cnt_inc = {redirect_act, ~ctrl.pc_en};

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_cnt
            pipe_hazard_ctrl_sat_counter #(
                .CNT_W(CNT_W)
            ) u_cnt (
                .clk  (clk),
                .rst  (rst),
                .inc  (cnt_inc[gi]),
                .count(cnt_val[gi])
            );
        end
    endgenerate

    assign stall_cnt = cnt_val[0];
    assign flush_cnt = cnt_val[1];

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: directed hazard scenarios plus randomized traffic
// against a rule-level model, on a default instance and a small one (CNT_W=2, MEM_TIMEOUT=4).
module tb_pipe_hazard_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic [4:0] id_rs, id_rt, ex_reg;
    logic       id_uses_rt, ex_MemRead, ex_redirect;
    logic       mem_MemRead, mem_MemWrite, mem_ready;

    logic a_pc, a_ifen, a_iffl, a_idexen, a_idexfl, a_exmem, a_mwbfl, a_err;
    logic b_pc, b_ifen, b_iffl, b_idexen, b_idexfl, b_exmem, b_mwbfl, b_err;
    logic [15:0] stall0, flush0;
    logic [1:0]  stall1, flush1;
    logic [7:0]  got0, got1;

    // Packed output order: pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_en, mem_wb_flush, mem_err
    assign got0 = {a_pc, a_ifen, a_iffl, a_idexen, a_idexfl, a_exmem, a_mwbfl, a_err};
    assign got1 = {b_pc, b_ifen, b_iffl, b_idexen, b_idexfl, b_exmem, b_mwbfl, b_err};

    localparam logic [7:0] O_NORMAL = 8'hD4;
    localparam logic [7:0] O_LOADU  = 8'h1C;
    localparam logic [7:0] O_REDIR  = 8'hFC;
    localparam logic [7:0] O_BUSY   = 8'h02;
    localparam logic [7:0] O_ERR    = 8'h01;

    pipe_hazard_ctrl #(.REG_W(5), .CNT_W(16), .MEM_TIMEOUT(64)) dut (
        .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
        .ex_MemRead(ex_MemRead), .ex_reg(ex_reg), .ex_redirect(ex_redirect),
        .mem_MemRead(mem_MemRead), .mem_MemWrite(mem_MemWrite), .mem_ready(mem_ready),
        .pc_en(a_pc), .if_id_en(a_ifen), .if_id_flush(a_iffl), .id_ex_en(a_idexen),
        .id_ex_flush(a_idexfl), .ex_mem_en(a_exmem), .mem_wb_flush(a_mwbfl),
        .mem_err(a_err), .stall_cnt(stall0), .flush_cnt(flush0)
    );

    pipe_hazard_ctrl #(.REG_W(5), .CNT_W(2), .MEM_TIMEOUT(4)) dut_s (
        .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
        .ex_MemRead(ex_MemRead), .ex_reg(ex_reg), .ex_redirect(ex_redirect),
        .mem_MemRead(mem_MemRead), .mem_MemWrite(mem_MemWrite), .mem_ready(mem_ready),
        .pc_en(b_pc), .if_id_en(b_ifen), .if_id_flush(b_iffl), .id_ex_en(b_idexen),
        .id_ex_flush(b_idexfl), .ex_mem_en(b_exmem), .mem_wb_flush(b_mwbfl),
        .mem_err(b_err), .stall_cnt(stall1), .flush_cnt(flush1)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: per instance, an error flag, the length of the current
    // unbroken run of busy memory cycles, and the two event counts.
    int m_err    [2];
    int m_streak [2];
    int m_stall  [2];
    int m_flush  [2];
    int m_tmo    [2] = '{64, 4};
    int m_cmax   [2] = '{65535, 3};

    function automatic logic [7:0] exp_outs(int k);
        logic busy, lu;
        busy = (mem_MemRead || mem_MemWrite) && !mem_ready;
        lu   = ex_MemRead && (ex_reg != 0) &&
               ((ex_reg == id_rs) || (id_uses_rt && (ex_reg == id_rt)));
        if (rst)            return O_NORMAL;
        if (m_err[k] != 0)  return O_ERR;
        if (busy)           return O_BUSY;
        if (ex_redirect)    return O_REDIR;
        if (lu)             return O_LOADU;
        return O_NORMAL;
    endfunction

    // Advance one clock; the model consumes the inputs held across the edge.
    task automatic tick();
        logic [7:0] o;
        logic busy;
        @(posedge clk);
        busy = (mem_MemRead || mem_MemWrite) && !mem_ready;
        for (int k = 0; k < 2; k++) begin
            o = exp_outs(k);
            if (rst) begin
                m_err[k] = 0; m_streak[k] = 0; m_stall[k] = 0; m_flush[k] = 0;
            end else begin
                if (!o[7] && m_stall[k] < m_cmax[k]) m_stall[k]++;
                if (o == O_REDIR && m_flush[k] < m_cmax[k]) m_flush[k]++;
                if (m_err[k] == 0) begin
                    if (busy) begin
                        // The first busy cycle happens in RUN, then MEM_TIMEOUT wait cycles are tolerated.
                        m_streak[k]++;
                        if (m_streak[k] == m_tmo[k] + 1) m_err[k] = 1;
                    end else begin
                        m_streak[k] = 0;
                    end
                end
            end
        end
        #1;
    endtask

    task automatic set_idle();
        id_rs = 5'd0; id_rt = 5'd0; ex_reg = 5'd0; id_uses_rt = 1'b0;
        ex_MemRead = 1'b0; ex_redirect = 1'b0;
        mem_MemRead = 1'b0; mem_MemWrite = 1'b0; mem_ready = 1'b0;
    endtask

    task automatic pulse_reset();
        set_idle();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic set_load_use();
        ex_MemRead = 1'b1; ex_reg = 5'd2; id_rs = 5'd2; id_rt = 5'd7; id_uses_rt = 1'b1;
    endtask

    task automatic test_reset();
        set_idle();
        rst = 1'b1;
        mem_MemRead = 1'b1; ex_redirect = 1'b1;
        @(negedge clk);
        checks++;
        if (got0 !== O_NORMAL) begin errors++; $display("FAIL reset_outs got %h want %h", got0, O_NORMAL); end
        checks++;
        if (got1 !== O_NORMAL) begin errors++; $display("FAIL reset_outs_s got %h want %h", got1, O_NORMAL); end
        tick();
        tick();
        rst = 1'b0;
        set_idle();
        @(negedge clk);
        checks++;
        if (stall0 !== 16'd0 || flush0 !== 16'd0) begin
            errors++; $display("FAIL reset_cnt got stall %0d flush %0d want 0 0", stall0, flush0);
        end
        checks++;
        if (got0 !== O_NORMAL) begin errors++; $display("FAIL reset_run got %h want %h", got0, O_NORMAL); end
        tick();
        $display("test_reset done");
    endtask

    task automatic test_load_use();
        pulse_reset();
        set_load_use();
        @(negedge clk);
        checks++;
        if (got0 !== O_LOADU) begin errors++; $display("FAIL load_use got %h want %h", got0, O_LOADU); end
        tick();
        set_idle();
        @(negedge clk);
        checks++;
        if (got0 !== O_NORMAL) begin errors++; $display("FAIL load_use_bubble got %h want %h", got0, O_NORMAL); end
        checks++;
        if (stall0 !== 16'd1) begin errors++; $display("FAIL load_use_stall got %0d want 1", stall0); end
        tick();
        // rt dependency only counts when the ID instruction actually reads rt
        ex_MemRead = 1'b1; ex_reg = 5'd9; id_rs = 5'd3; id_rt = 5'd9; id_uses_rt = 1'b0;
        @(negedge clk);
        checks++;
        if (got0 !== O_NORMAL) begin errors++; $display("FAIL rt_unused got %h want %h", got0, O_NORMAL); end
        tick();
        id_uses_rt = 1'b1;
        @(negedge clk);
        checks++;
        if (got0 !== O_LOADU) begin errors++; $display("FAIL rt_used got %h want %h", got0, O_LOADU); end
        tick();
        $display("test_load_use done");
    endtask

    task automatic test_r0_exempt();
        pulse_reset();
        ex_MemRead = 1'b1; ex_reg = 5'd0; id_rs = 5'd0; id_rt = 5'd0; id_uses_rt = 1'b1;
        @(negedge clk);
        checks++;
        if (got0 !== O_NORMAL) begin errors++; $display("FAIL r0_exempt got %h want %h", got0, O_NORMAL); end
        tick();
        set_idle();
        @(negedge clk);
        checks++;
        if (stall0 !== 16'd0) begin errors++; $display("FAIL r0_stall got %0d want 0", stall0); end
        tick();
        $display("test_r0_exempt done");
    endtask

    task automatic test_redirect_priority();
        pulse_reset();
        set_load_use();
        ex_redirect = 1'b1;
        @(negedge clk);
        checks++;
        if (got0 !== O_REDIR) begin errors++; $display("FAIL redirect got %h want %h", got0, O_REDIR); end
        tick();
        set_idle();
        @(negedge clk);
        checks++;
        if (flush0 !== 16'd1 || stall0 !== 16'd0) begin
            errors++; $display("FAIL redirect_cnt got flush %0d stall %0d want 1 0", flush0, stall0);
        end
        tick();
        $display("test_redirect_priority done");
    endtask

    task automatic test_mem_wait();
        pulse_reset();
        mem_MemRead = 1'b1; mem_ready = 1'b0;
        set_load_use();
        ex_redirect = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (got0 !== O_BUSY) begin errors++; $display("FAIL mem_wait c%0d got %h want %h", i, got0, O_BUSY); end
            checks++;
            if (got1 !== O_BUSY) begin errors++; $display("FAIL mem_wait_s c%0d got %h want %h", i, got1, O_BUSY); end
            tick();
        end
        set_idle();
        mem_MemRead = 1'b1; mem_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (got0 !== O_NORMAL) begin errors++; $display("FAIL mem_done got %h want %h", got0, O_NORMAL); end
        tick();
        set_idle();
        @(negedge clk);
        checks++;
        if (stall0 !== 16'd3) begin errors++; $display("FAIL mem_stall got %0d want 3", stall0); end
        tick();
        $display("test_mem_wait done");
    endtask

    task automatic test_timeout();
        logic [7:0] want;
        pulse_reset();
        mem_MemWrite = 1'b1; mem_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            want = (i >= 5) ? O_ERR : O_BUSY;
            @(negedge clk);
            checks++;
            if (got1 !== want) begin errors++; $display("FAIL timeout c%0d got %h want %h", i, got1, want); end
            checks++;
            if (got0 !== O_BUSY) begin errors++; $display("FAIL no_timeout c%0d got %h want %h", i, got0, O_BUSY); end
            tick();
        end
        set_idle();
        @(negedge clk);
        checks++;
        if (got1 !== O_ERR) begin errors++; $display("FAIL err_sticky got %h want %h", got1, O_ERR); end
        tick();
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (got1 !== O_NORMAL) begin errors++; $display("FAIL err_in_rst got %h want %h", got1, O_NORMAL); end
        tick();
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (got1 !== O_NORMAL || stall1 !== 2'd0 || flush1 !== 2'd0) begin
            errors++; $display("FAIL err_cleared got %h stall %0d flush %0d want %h 0 0", got1, stall1, flush1, O_NORMAL);
        end
        tick();
        $display("test_timeout done");
    endtask

    task automatic test_saturation();
        pulse_reset();
        for (int i = 0; i < 5; i++) begin
            set_load_use();
            tick();
            set_idle();
            tick();
        end
        @(negedge clk);
        checks++;
        if (stall1 !== 2'd3) begin errors++; $display("FAIL sat_stall got %0d want 3", stall1); end
        checks++;
        if (stall0 !== 16'd5) begin errors++; $display("FAIL wide_stall got %0d want 5", stall0); end
        tick();
        $display("test_saturation done");
    endtask

    task automatic test_random();
        int n_err = 0;
        for (int c = 0; c < 3000; c++) begin
            rst          = ($urandom_range(0, 59) == 0);
            id_rs        = 5'($urandom_range(0, 3));
            id_rt        = 5'($urandom_range(0, 3));
            ex_reg       = 5'($urandom_range(0, 3));
            id_uses_rt   = 1'($urandom_range(0, 1));
            ex_MemRead   = 1'($urandom_range(0, 1));
            ex_redirect  = ($urandom_range(0, 5) == 0);
            mem_MemRead  = ($urandom_range(0, 3) == 0);
            mem_MemWrite = ($urandom_range(0, 5) == 0);
            mem_ready    = 1'($urandom_range(0, 1));
            @(negedge clk);
            checks++;
            if (got0 !== exp_outs(0)) begin errors++; n_err++; $display("FAIL rnd_outs c%0d got %h want %h", c, got0, exp_outs(0)); end
            checks++;
            if (got1 !== exp_outs(1)) begin errors++; n_err++; $display("FAIL rnd_outs_s c%0d got %h want %h", c, got1, exp_outs(1)); end
            checks++;
            if (stall0 !== 16'(m_stall[0])) begin errors++; n_err++; $display("FAIL rnd_stall c%0d got %0d want %0d", c, stall0, m_stall[0]); end
            checks++;
            if (stall1 !== 2'(m_stall[1])) begin errors++; n_err++; $display("FAIL rnd_stall_s c%0d got %0d want %0d", c, stall1, m_stall[1]); end
            checks++;
            if (flush0 !== 16'(m_flush[0])) begin errors++; n_err++; $display("FAIL rnd_flush c%0d got %0d want %0d", c, flush0, m_flush[0]); end
            checks++;
            if (flush1 !== 2'(m_flush[1])) begin errors++; n_err++; $display("FAIL rnd_flush_s c%0d got %0d want %0d", c, flush1, m_flush[1]); end
            tick();
        end
        $display("test_random done, %0d discrepancies", n_err);
    endtask

    initial begin
        rst = 1'b1;
        set_idle();
        for (int k = 0; k < 2; k++) begin
            m_err[k] = 0; m_streak[k] = 0; m_stall[k] = 0; m_flush[k] = 0;
        end
        #1;
        test_reset();
        test_load_use();
        test_r0_exempt();
        test_redirect_priority();
        test_mem_wait();
        test_timeout();
        test_saturation();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
